// File: rtl/boxcar_decimator_pkg.sv
// Shared constants and helpers for the boxcar decimator slice.
package boxcar_decimator_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_LOG2_MAX = 10;

  function automatic logic [7:0] clamp_exp(input logic [7:0] req, input logic [7:0] max_exp);
    if (req > max_exp) begin
      return max_exp;
    end else begin
      return req;
    end
  endfunction

endpackage

// File: rtl/boxcar_decimator_if.sv
// Sample-stream bus between the upstream filter side and the boxcar decimator.
interface boxcar_decimator_if #(
  parameter int WIDTH    = 16,
  parameter int LOG2_MAX = 10,
  localparam int NW      = $clog2(LOG2_MAX + 1)
) ();

  logic [WIDTH-1:0]  data_i;
  logic              valid_i;
  logic [NW-1:0]     log2_n_i;
  logic              clear_i;
  logic [WIDTH-1:0]  data_o;
  logic              valid_o;
  logic [LOG2_MAX:0] fill_o;

  modport master (
    output data_i, valid_i, log2_n_i, clear_i,
    input  data_o, valid_o, fill_o
  );

  modport slave (
    input  data_i, valid_i, log2_n_i, clear_i,
    output data_o, valid_o, fill_o
  );

endinterface

// File: rtl/boxcar_decimator_window_counter.sv
// Window length latch and sample counter; flags the first and last sample of each window.
module window_counter
  import boxcar_decimator_pkg::*;
#(
  parameter int LOG2_MAX = DEF_LOG2_MAX,
  localparam int NW      = $clog2(LOG2_MAX + 1),
  localparam int CW      = LOG2_MAX + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  input  logic          clear_i,
  input  logic [NW-1:0] log2_n_i,
  output logic          start_o,
  output logic          last_o,
  output logic [NW-1:0] n_o,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_r;
  logic [NW-1:0] n_r;
  logic [NW-1:0] req_s;
  logic [NW-1:0] n_eff_s;
  logic [CW-1:0] term_s;
  logic          accept_s;
  logic          start_s;
  logic          last_s;

  // Exponent in force for this sample: freshly latched at a window start, else the held one
  always_comb begin
    req_s    = NW'(clamp_exp(8'(log2_n_i), 8'(LOG2_MAX)));
    accept_s = valid_i & ~clear_i;
    start_s  = accept_s && (cnt_r == {CW{1'b0}});
    if (start_s) begin
      n_eff_s = req_s;
    end else begin
      n_eff_s = n_r;
    end
    term_s = ({{(CW-1){1'b0}}, 1'b1} << n_eff_s) - {{(CW-1){1'b0}}, 1'b1};
    last_s = accept_s && (cnt_r == term_s);
  end

  // Counter and exponent registers; clear flushes the partial window
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r <= {CW{1'b0}};
      n_r   <= {NW{1'b0}};
    end else if (clear_i) begin
      cnt_r <= {CW{1'b0}};
    end else if (valid_i) begin
      if (start_s) begin
        n_r <= req_s;
      end
      if (last_s) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign start_o = start_s;
  assign last_o  = last_s;
  assign n_o     = n_eff_s;
  assign cnt_o   = cnt_r;

endmodule

// File: rtl/boxcar_decimator.sv
// Decimating boxcar averager: sums 2^N valid samples and emits their floor-mean with a strobe.
module boxcar_decimator
  import boxcar_decimator_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOG2_MAX = DEF_LOG2_MAX
) (
  input  logic             clk_i,
  input  logic             rst_i,
  boxcar_decimator_if.slave bus
);

  localparam int NW = $clog2(LOG2_MAX + 1);
  localparam int AW = WIDTH + LOG2_MAX;

  logic                 start_s;
  logic                 last_s;
  logic [NW-1:0]        n_s;
  logic [LOG2_MAX:0]    cnt_s;
  logic signed [AW-1:0] acc_r;
  logic signed [AW-1:0] base_s;
  logic signed [AW-1:0] sum_s;
  logic [WIDTH-1:0]     mean_s;
  logic [WIDTH-1:0]     data_r;
  logic                 valid_r;

  window_counter #(.LOG2_MAX(LOG2_MAX)) u_window_counter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (bus.valid_i),
    .clear_i  (bus.clear_i),
    .log2_n_i (bus.log2_n_i),
    .start_o  (start_s),
    .last_o   (last_s),
    .n_o      (n_s),
    .cnt_o    (cnt_s)
  );

  // Running sum; a window start never inherits a stale partial sum
  always_comb begin
    if (start_s) begin
      base_s = {AW{1'b0}};
    end else begin
      base_s = acc_r;
    end
    sum_s  = base_s + $signed({{LOG2_MAX{bus.data_i[WIDTH-1]}}, bus.data_i});
    mean_s = WIDTH'(sum_s >>> n_s);
  end

  // Accumulator and output registers; clear outranks window completion
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_r   <= {AW{1'b0}};
      data_r  <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
    end else if (bus.clear_i) begin
      acc_r   <= {AW{1'b0}};
      valid_r <= 1'b0;
    end else if (bus.valid_i) begin
      if (last_s) begin
        acc_r   <= {AW{1'b0}};
        data_r  <= mean_s;
        valid_r <= 1'b1;
      end else begin
        acc_r   <= sum_s;
        valid_r <= 1'b0;
      end
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign bus.data_o  = data_r;
  assign bus.valid_o = valid_r;
  assign bus.fill_o  = cnt_s;

endmodule

// File: tb/tb_boxcar_decimator.sv
// Directed self-checking bench for boxcar_decimator with hand-computed expectations.
module tb_boxcar_decimator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  boxcar_decimator_if #(.WIDTH(16), .LOG2_MAX(10)) bus ();

  boxcar_decimator #(.WIDTH(16), .LOG2_MAX(10)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dout();
    return int'($signed(bus.data_o));
  endfunction

  // Apply one cycle of inputs, then sample just after the capturing edge
  task automatic cyc(input int d, input bit v, input bit c);
    bus.data_i  = 16'(d);
    bus.valid_i = v;
    bus.clear_i = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.data_i   = 16'd0;
    bus.valid_i  = 1'b0;
    bus.clear_i  = 1'b0;
    bus.log2_n_i = 4'd3;

    // Reset state
    cyc(0, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b0);
    chk("rst_data", dout(), 0);
    chk("rst_valid", int'(bus.valid_o), 0);
    chk("rst_fill", int'(bus.fill_o), 0);
    rst = 1'b0;

    // Load a nonzero output, then reset mid-window
    bus.log2_n_i = 4'd0;
    cyc(55, 1'b1, 1'b0);
    chk("pre_rst_data", dout(), 55);
    bus.log2_n_i = 4'd3;
    for (int i = 0; i < 5; i++) cyc(7, 1'b1, 1'b0);
    chk("pre_rst_fill", int'(bus.fill_o), 5);
    rst = 1'b1;
    cyc(7, 1'b1, 1'b0);
    chk("midrst_data", dout(), 0);
    chk("midrst_valid", int'(bus.valid_o), 0);
    chk("midrst_fill", int'(bus.fill_o), 0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc(i, 1'b1, 1'b0);
      if (i == 7) chk("post_rst_nostrobe", int'(bus.valid_o), 0);
    end
    chk("post_rst_valid", int'(bus.valid_o), 1);
    chk("post_rst_data", dout(), 4);

    // N=2 continuous: 4,8,12,16 -> mean 10 every 4 cycles
    bus.log2_n_i = 4'd2;
    for (int i = 0; i < 12; i++) begin
      cyc(4 * (i % 4 + 1), 1'b1, 1'b0);
      chk($sformatf("n2_valid_%0d", i), int'(bus.valid_o), (i % 4 == 3) ? 1 : 0);
      chk($sformatf("n2_fill_%0d", i), int'(bus.fill_o), (i + 1) % 4);
      if (i % 4 == 3) chk($sformatf("n2_data_%0d", i), dout(), 10);
    end

    // Floor rounding: (-3 + -4) >>> 1 = -4
    bus.log2_n_i = 4'd1;
    cyc(-3, 1'b1, 1'b0);
    chk("floor_nostrobe", int'(bus.valid_o), 0);
    cyc(-4, 1'b1, 1'b0);
    chk("floor_valid", int'(bus.valid_o), 1);
    chk("floor_data", dout(), -4);

    // Extremes: 1024 samples of -32768
    bus.log2_n_i = 4'd10;
    for (int i = 0; i < 1024; i++) begin
      cyc(-32768, 1'b1, 1'b0);
      if (i == 1022) begin
        chk("ext_nostrobe", int'(bus.valid_o), 0);
        chk("ext_fill", int'(bus.fill_o), 1023);
      end
    end
    chk("ext_valid", int'(bus.valid_o), 1);
    chk("ext_data", dout(), -32768);

    // Gapped input, N=3: 10..80 -> mean 45
    bus.log2_n_i = 4'd3;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("gap_fill_%0d", k), int'(bus.fill_o), k);
      cyc(10 * (k + 1), 1'b1, 1'b0);
      chk($sformatf("gap_valid_%0d", k), int'(bus.valid_o), (k == 7) ? 1 : 0);
      cyc(999, 1'b0, 1'b0);
      chk($sformatf("gap_idle_%0d", k), int'(bus.valid_o), 0);
    end
    chk("gap_data", dout(), 45);

    // Mid-window change of N from 2 to 4
    bus.log2_n_i = 4'd2;
    cyc(100, 1'b1, 1'b0);
    cyc(100, 1'b1, 1'b0);
    bus.log2_n_i = 4'd4;
    cyc(100, 1'b1, 1'b0);
    cyc(100, 1'b1, 1'b0);
    chk("chg_first_valid", int'(bus.valid_o), 1);
    chk("chg_first_data", dout(), 100);
    for (int i = 0; i < 16; i++) begin
      cyc(i, 1'b1, 1'b0);
      if (i == 3 || i == 14) chk($sformatf("chg_nostrobe_%0d", i), int'(bus.valid_o), 0);
    end
    chk("chg_second_valid", int'(bus.valid_o), 1);
    chk("chg_second_data", dout(), 7);

    // Out-of-range N clamps to 10
    bus.log2_n_i = 4'd15;
    for (int i = 0; i < 1024; i++) begin
      cyc(5, 1'b1, 1'b0);
      if (i == 999) chk("clamp_fill", int'(bus.fill_o), 1000);
      if (i == 1022) chk("clamp_nostrobe", int'(bus.valid_o), 0);
    end
    chk("clamp_valid", int'(bus.valid_o), 1);
    chk("clamp_data", dout(), 5);

    // Clear on the would-be last sample of an N=2 window
    bus.log2_n_i = 4'd2;
    for (int i = 0; i < 3; i++) cyc(50, 1'b1, 1'b0);
    cyc(9, 1'b1, 1'b1);
    chk("clr_valid", int'(bus.valid_o), 0);
    chk("clr_fill", int'(bus.fill_o), 0);
    chk("clr_data", dout(), 5);

    // N=0 passthrough
    bus.log2_n_i = 4'd0;
    cyc(123, 1'b1, 1'b0);
    chk("n0_valid_a", int'(bus.valid_o), 1);
    chk("n0_data_a", dout(), 123);
    chk("n0_fill", int'(bus.fill_o), 0);
    cyc(-77, 1'b1, 1'b0);
    chk("n0_data_b", dout(), -77);
    cyc(0, 1'b0, 1'b0);
    chk("n0_idle_valid", int'(bus.valid_o), 0);
    chk("n0_hold_data", dout(), -77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
